i2cm_cmd_arb: RTL

- Round-robin arbiter and sequencer that shares one I2C-master command FIFO among NREQ requesters (CPU regs, sensor-init ROM, AE/AWB engines).
- Sits in the wclk domain in front of the FIFO write port. It drives push and the write data, and watches the FIFO's ff_full flag.
- A grant is locked for a whole multi-word I2C transaction, so words from different transactions never interleave.
- A stalled owner is evicted by timeout, and an abort word is pushed to close the partial transaction.

---
 rtl/i2cm_cmd_arb.sv | 130 +++++++++++++
 1 files changed

// File: rtl/i2cm_cmd_arb.sv
// Round-robin arbiter that shares one I2C-master command FIFO write port among
// NREQ requesters, locking the grant per transaction and evicting stalled owners.
module i2cm_cmd_arb #(
   parameter int              NREQ      = 4,
   parameter int              DW        = 16,
   parameter int              TO_CYC    = 255,
   parameter int              TO_W      = 8,
   parameter logic [DW-1:0]   ABORT_CMD = {DW{1'b1}},
   parameter int              IDW       = $clog2(NREQ)
) (
   input  logic                 wclk,
   input  logic                 wrst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*DW-1:0]   req_data,
   input  logic [NREQ-1:0]      req_last,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 ff_full,
   input  logic                 wflush,
   output logic                 push,
   output logic [DW:0]          push_data,
   output logic [NREQ-1:0]      grant,
   output logic                 busy,
   output logic                 to_err,
   output logic [IDW-1:0]       to_id
);

   typedef enum logic [1:0] {IDLE, LOCK, ABORT} state_t;

   state_t            state;
   logic [IDW-1:0]    own;
   logic [IDW-1:0]    rr_ptr;
   logic [IDW-1:0]    winner;
   logic [TO_W-1:0]   to_cnt;

   // First valid requester strictly after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
      int   idx;
      logic found;
      idx    = 0;
      found  = 1'b0;
      winner = rr_ptr;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            winner = IDW'(idx);
            found  = 1'b1;
         end
      end
   end

   // Write-port outputs follow the current state; flush and reset silence them at once.
   always_comb begin
      req_ready = '0;
      push      = 1'b0;
      push_data = '0;
      if (wrst_n && !wflush) begin
         case (state)
            LOCK: begin
               req_ready[own] = ~ff_full;
               push           = req_valid[own] & ~ff_full;
               push_data      = {req_last[own], req_data[own*DW +: DW]};
            end
            ABORT: begin
               push      = ~ff_full;
               push_data = {1'b1, ABORT_CMD};
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         state  <= IDLE;
         grant  <= '0;
         own    <= '0;
         rr_ptr <= IDW'(NREQ-1);
         to_cnt <= '0;
         to_err <= 1'b0;
         to_id  <= '0;
      end else begin
         to_err <= 1'b0;
         if (wflush) begin
            state  <= IDLE;
            grant  <= '0;
            to_cnt <= '0;
         end else begin
            case (state)
               IDLE: if (|req_valid) begin
                  state  <= LOCK;
                  own    <= winner;
                  grant  <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
                  to_cnt <= '0;
               end
               LOCK: begin
                  if (req_valid[own]) begin
                     // A full FIFO stalls the owner without charging its timeout.
                     if (!ff_full) begin
                        if (req_last[own]) begin
                           rr_ptr <= own;
                           grant  <= '0;
                           state  <= IDLE;
                        end else begin
                           to_cnt <= '0;
                        end
                     end
                  end else if (to_cnt == TO_W'(TO_CYC-1)) begin
                     to_err <= 1'b1;
                     to_id  <= own;
                     rr_ptr <= own;
                     state  <= ABORT;
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                  end
               end
               ABORT: if (!ff_full) begin
                  grant <= '0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
